// File: rtl/ex_mem_pipe.sv
// ex_mem_pipe: EX-stage decode (ALU control, redirect, forwarding) feeding an EX/MEM buffer with optional 2-entry skid.
module ex_mem_pipe #(
  parameter int XLEN = 32,
  parameter int RW   = 5,
  parameter int SKID = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rvout,
  input  logic [XLEN-1:0] rv2,
  input  logic [5:0]      op,
  input  logic [1:0]      itype,
  input  logic [2:0]      sub_op,
  input  logic [RW-1:0]   rd,
  input  logic            is_load,
  input  logic            is_store,
  input  logic            is_nop,
  input  logic            flush,
  output logic [5:0]      alu_op,
  output logic            redir_valid,
  output logic [XLEN-1:0] redir_pc,
  output logic            fwd_rwe,
  output logic [RW-1:0]   fwd_rd,
  output logic [XLEN-1:0] fwd_wdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2:0]      out_sub_op,
  output logic [XLEN-1:0] out_daddr,
  output logic [XLEN-1:0] out_wdata,
  output logic [RW-1:0]   out_rd,
  output logic [XLEN-1:0] out_rv2,
  output logic            out_rwe,
  output logic            out_load,
  output logic            out_store
);
  typedef struct packed {
    logic [2:0]      sub_op;
    logic [XLEN-1:0] daddr;
    logic [XLEN-1:0] wdata;
    logic [RW-1:0]   rd;
    logic [XLEN-1:0] rv2;
    logic            rwe;
    logic            load;
    logic            store;
  } beat_t;
  beat_t head, skid, nb;
  logic hv, sv, acc, drain, v, rwe, taken;
  logic [XLEN-1:0] wdata, daddr, tgt;
  always_comb begin
    v = in_valid && !is_nop;
    alu_op = '0;
    rwe = 1'b0;
    wdata = '0;
    daddr = '0;
    taken = 1'b0;
    tgt = pc + imm;
    if (v) begin
      case (itype)
        2'b00: begin
          alu_op = op;
          rwe = 1'b1;
          wdata = rvout;
        end
        2'b01: begin
          alu_op = 6'b001000;
          daddr = rvout;
        end
        2'b10: begin
          alu_op = sub_op[2:1] == 2'b00 ? 6'b111000 : sub_op[2:1] == 2'b10 ? 6'b101010 :
                   sub_op[2:1] == 2'b11 ? 6'b101011 : 6'b0;
          taken = sub_op[2:1] == 2'b00 ? ((rvout == '0) ^ sub_op[0]) : (sub_op[2] && (rvout[0] ^ sub_op[0]));
        end
        default: begin
          rwe = 1'b1;
          alu_op = sub_op == 3'b100 ? 6'b001000 : 6'b0;
          taken = sub_op[2:1] == 2'b10;
          wdata = taken ? pc + XLEN'(4) : sub_op == 3'b010 ? pc + imm : sub_op == 3'b110 ? imm : '0;
          tgt = sub_op == 3'b100 ? {rvout[XLEN-1:1], 1'b0} : pc + imm;
        end
      endcase
    end
  end
  assign in_ready    = !reset && (SKID != 0 ? !sv : (!hv || out_ready));
  assign acc         = in_valid && in_ready && !flush;
  assign drain       = hv && out_ready;
  assign redir_valid = taken && in_ready && !flush;
  assign redir_pc    = tgt;
  assign fwd_rwe     = rwe && rd != '0;
  assign fwd_rd      = rd;
  assign fwd_wdata   = wdata;
  assign nb = '{sub_op: sub_op, daddr: daddr, wdata: wdata, rd: is_nop ? '0 : rd, rv2: rv2,
                rwe: rwe, load: is_load && !is_nop, store: is_store && !is_nop};
  // the skid slot only fills while head is stalled, so FIFO order holds by construction
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hv <= 1'b0;
      sv <= 1'b0;
      head <= '0;
      skid <= '0;
    end else if (flush) begin
      hv <= 1'b0;
      sv <= 1'b0;
    end else if (sv) begin
      if (drain) begin
        head <= skid;
        sv <= 1'b0;
      end
    end else if (acc) begin
      if (!hv || drain) begin
        head <= nb;
        hv <= 1'b1;
      end else begin
        skid <= nb;
        sv <= 1'b1;
      end
    end else if (drain) begin
      hv <= 1'b0;
    end
  end
  assign out_valid  = hv;
  assign out_sub_op = head.sub_op;
  assign out_daddr  = head.daddr;
  assign out_wdata  = head.wdata;
  assign out_rd     = head.rd;
  assign out_rv2    = head.rv2;
  assign out_rwe    = hv && head.rwe;
  assign out_load   = hv && head.load;
  assign out_store  = hv && head.store;
endmodule

// File: tb/tb_ex_mem_pipe.sv
// tb_ex_mem_pipe: directed scenarios plus randomized traffic checked against a queue-based reference model.
module tb_ex_mem_pipe;
  logic clk = 0, reset = 1, in_valid = 0, in_ready, is_load = 0, is_store = 0, is_nop = 0, flush = 0;
  logic [31:0] pc = 0, imm = 0, rvout = 0, rv2 = 0;
  logic [5:0] op = 0, alu_op;
  logic [1:0] itype = 0;
  logic [2:0] sub_op = 0, out_sub_op;
  logic [4:0] rd = 0, fwd_rd, out_rd;
  logic redir_valid, fwd_rwe, out_valid, out_ready = 0, out_rwe, out_load, out_store;
  logic [31:0] redir_pc, fwd_wdata, out_daddr, out_wdata, out_rv2;
  int pass_cnt = 0, tot_cnt = 0;

  typedef struct packed {
    logic [2:0] s; logic [31:0] da, wd; logic [4:0] rd; logic [31:0] rv2; logic w, ld, st;
  } mb_t;
  mb_t q[$];

  ex_mem_pipe dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .pc(pc), .imm(imm),
    .rvout(rvout), .rv2(rv2), .op(op), .itype(itype), .sub_op(sub_op), .rd(rd),
    .is_load(is_load), .is_store(is_store), .is_nop(is_nop), .flush(flush), .alu_op(alu_op),
    .redir_valid(redir_valid), .redir_pc(redir_pc), .fwd_rwe(fwd_rwe), .fwd_rd(fwd_rd),
    .fwd_wdata(fwd_wdata), .out_valid(out_valid), .out_ready(out_ready), .out_sub_op(out_sub_op),
    .out_daddr(out_daddr), .out_wdata(out_wdata), .out_rd(out_rd), .out_rv2(out_rv2),
    .out_rwe(out_rwe), .out_load(out_load), .out_store(out_store)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic [1:0] it, input logic [2:0] so, input logic [5:0] o,
                          input logic [31:0] p, input logic [31:0] im, input logic [31:0] rv,
                          input logic [4:0] r);
    itype = it; sub_op = so; op = o; pc = p; imm = im; rvout = rv; rd = r;
    is_nop = 0; is_load = 0; is_store = 0; in_valid = 1;
  endtask

  // reference decode straight from the instruction-class rules
  function automatic void dec(output logic [5:0] a, output logic w, output logic [31:0] wd,
                              output logic [31:0] da, output logic tk, output logic [31:0] tg);
    a = 0; w = 0; wd = 0; da = 0; tk = 0; tg = pc + imm;
    if (!in_valid || is_nop) return;
    if (itype == 2'b00) begin a = op; w = 1; wd = rvout; end
    else if (itype == 2'b01) begin a = 6'b001000; da = rvout; end
    else if (itype == 2'b10) begin
      if (sub_op == 3'b000) begin a = 6'b111000; tk = (rvout == 0); end
      else if (sub_op == 3'b001) begin a = 6'b111000; tk = (rvout != 0); end
      else if (sub_op == 3'b100) begin a = 6'b101010; tk = rvout[0]; end
      else if (sub_op == 3'b101) begin a = 6'b101010; tk = !rvout[0]; end
      else if (sub_op == 3'b110) begin a = 6'b101011; tk = rvout[0]; end
      else if (sub_op == 3'b111) begin a = 6'b101011; tk = !rvout[0]; end
    end else begin
      w = 1;
      if (sub_op == 3'b100) begin a = 6'b001000; wd = pc + 4; tk = 1; tg = rvout & ~32'd1; end
      else if (sub_op == 3'b101) begin wd = pc + 4; tk = 1; end
      else if (sub_op == 3'b010) wd = pc + imm;
      else if (sub_op == 3'b110) wd = imm;
    end
  endfunction

  task automatic test_reset();
    reset = 1;
    set_beat(2'b10, 3'b000, 0, 32'h100, 32'h20, 0, 3);
    #1;
    tot_cnt++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready got %h exp 0", in_ready); else pass_cnt++;
    tot_cnt++; if (redir_valid !== 1'b0) $display("FAIL rst_redir got %h exp 0", redir_valid); else pass_cnt++;
    tot_cnt++; if ({out_valid, out_wdata, out_rd, out_rwe} !== '0) $display("FAIL rst_out got %h exp 0", {out_valid, out_wdata, out_rd, out_rwe}); else pass_cnt++;
    step(); step();
    in_valid = 0; reset = 0;
    #1;
    tot_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_release_ready got %h exp 1", in_ready); else pass_cnt++;
    step();
  endtask

  task automatic test_alu();
    out_ready = 1;
    set_beat(2'b00, 3'b000, 6'b100000, 0, 0, 32'h1234, 7);
    #1;
    tot_cnt++; if ({fwd_rwe, fwd_rd, fwd_wdata} !== {1'b1, 5'd7, 32'h1234}) $display("FAIL alu_fwd got %h exp %h", {fwd_rwe, fwd_rd, fwd_wdata}, {1'b1, 5'd7, 32'h1234}); else pass_cnt++;
    tot_cnt++; if (alu_op !== 6'b100000) $display("FAIL alu_op got %b exp 100000", alu_op); else pass_cnt++;
    step();
    in_valid = 0;
    #1;
    tot_cnt++; if ({out_valid, out_wdata, out_rd, out_rwe} !== {1'b1, 32'h1234, 5'd7, 1'b1}) $display("FAIL alu_out got %h exp %h", {out_valid, out_wdata, out_rd, out_rwe}, {1'b1, 32'h1234, 5'd7, 1'b1}); else pass_cnt++;
    step();
    tot_cnt++; if (out_valid !== 1'b0) $display("FAIL alu_drain got %h exp 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_branch();
    set_beat(2'b10, 3'b000, 0, 32'h100, 32'h20, 0, 0);
    #1;
    tot_cnt++; if ({redir_valid, redir_pc, alu_op} !== {1'b1, 32'h120, 6'b111000}) $display("FAIL beq_taken got %h exp %h", {redir_valid, redir_pc, alu_op}, {1'b1, 32'h120, 6'b111000}); else pass_cnt++;
    rvout = 1;
    #1;
    tot_cnt++; if (redir_valid !== 1'b0) $display("FAIL beq_not_taken got %h exp 0", redir_valid); else pass_cnt++;
    sub_op = 3'b100;
    #1;
    tot_cnt++; if ({redir_valid, alu_op} !== {1'b1, 6'b101010}) $display("FAIL blt_taken got %h exp %h", {redir_valid, alu_op}, {1'b1, 6'b101010}); else pass_cnt++;
    flush = 1;
    #1;
    tot_cnt++; if (redir_valid !== 1'b0) $display("FAIL br_flush got %h exp 0", redir_valid); else pass_cnt++;
    flush = 0; in_valid = 0;
    #1;
    tot_cnt++; if (redir_valid !== 1'b0) $display("FAIL br_invalid got %h exp 0", redir_valid); else pass_cnt++;
  endtask

  task automatic test_jump();
    set_beat(2'b11, 3'b100, 0, 32'h40, 0, 32'h203, 1);
    #1;
    tot_cnt++; if ({redir_valid, redir_pc, fwd_wdata, alu_op} !== {1'b1, 32'h202, 32'h44, 6'b001000}) $display("FAIL jalr got %h exp %h", {redir_valid, redir_pc, fwd_wdata, alu_op}, {1'b1, 32'h202, 32'h44, 6'b001000}); else pass_cnt++;
    set_beat(2'b11, 3'b101, 0, 32'hFFFFFFFC, 8, 0, 1);
    #1;
    tot_cnt++; if ({redir_valid, redir_pc, fwd_wdata} !== {1'b1, 32'h4, 32'h0}) $display("FAIL jal_wrap got %h exp %h", {redir_valid, redir_pc, fwd_wdata}, {1'b1, 32'h4, 32'h0}); else pass_cnt++;
    set_beat(2'b11, 3'b110, 0, 32'h10, 32'hABCD000, 0, 2);
    #1;
    tot_cnt++; if ({redir_valid, fwd_rwe, fwd_wdata} !== {1'b0, 1'b1, 32'hABCD000}) $display("FAIL lui got %h exp %h", {redir_valid, fwd_rwe, fwd_wdata}, {1'b0, 1'b1, 32'hABCD000}); else pass_cnt++;
    rd = 0;
    #1;
    tot_cnt++; if (fwd_rwe !== 1'b0) $display("FAIL fwd_rd0 got %h exp 0", fwd_rwe); else pass_cnt++;
    in_valid = 0;
    step(); step();
  endtask

  task automatic test_skid();
    out_ready = 0;
    set_beat(2'b00, 0, 0, 0, 0, 32'hAAAA, 1);
    step();
    set_beat(2'b00, 0, 0, 0, 0, 32'hBBBB, 2);
    #1;
    tot_cnt++; if (in_ready !== 1'b1) $display("FAIL skid_ready_b got %h exp 1", in_ready); else pass_cnt++;
    step();
    in_valid = 0;
    #1;
    tot_cnt++; if ({in_ready, out_valid, out_wdata} !== {1'b0, 1'b1, 32'hAAAA}) $display("FAIL skid_full got %h exp %h", {in_ready, out_valid, out_wdata}, {1'b0, 1'b1, 32'hAAAA}); else pass_cnt++;
    step();
    tot_cnt++; if ({in_ready, out_valid, out_wdata, out_rd} !== {1'b0, 1'b1, 32'hAAAA, 5'd1}) $display("FAIL skid_hold got %h exp %h", {in_ready, out_valid, out_wdata, out_rd}, {1'b0, 1'b1, 32'hAAAA, 5'd1}); else pass_cnt++;
    out_ready = 1;
    step();
    tot_cnt++; if ({in_ready, out_valid, out_wdata, out_rd} !== {1'b1, 1'b1, 32'hBBBB, 5'd2}) $display("FAIL skid_second got %h exp %h", {in_ready, out_valid, out_wdata, out_rd}, {1'b1, 1'b1, 32'hBBBB, 5'd2}); else pass_cnt++;
    step();
    tot_cnt++; if (out_valid !== 1'b0) $display("FAIL skid_empty got %h exp 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_flush();
    out_ready = 0;
    set_beat(2'b00, 0, 0, 0, 0, 32'h11, 3);
    step(); step();
    set_beat(2'b10, 3'b000, 0, 32'h100, 32'h20, 0, 0);
    flush = 1;
    #1;
    tot_cnt++; if ({in_ready, redir_valid} !== 2'b00) $display("FAIL flush_full_in got %b exp 00", {in_ready, redir_valid}); else pass_cnt++;
    step();
    flush = 0; in_valid = 0;
    #1;
    tot_cnt++; if ({out_valid, in_ready} !== 2'b01) $display("FAIL flush_cleared got %b exp 01", {out_valid, in_ready}); else pass_cnt++;
    set_beat(2'b00, 0, 0, 0, 0, 32'h22, 4);
    flush = 1;
    step();
    flush = 0; in_valid = 0;
    #1;
    tot_cnt++; if (out_valid !== 1'b0) $display("FAIL flush_drop got %h exp 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_nop_reset();
    out_ready = 0;
    set_beat(2'b00, 0, 6'b100000, 0, 0, 32'h55, 9);
    is_nop = 1; is_load = 1;
    #1;
    tot_cnt++; if ({fwd_rwe, alu_op} !== 7'b0) $display("FAIL nop_fwd got %h exp 0", {fwd_rwe, alu_op}); else pass_cnt++;
    step();
    is_nop = 0; is_load = 0; rd = 6;
    #1;
    tot_cnt++; if ({out_valid, out_rd, out_rwe, out_load} !== {1'b1, 5'd0, 1'b0, 1'b0}) $display("FAIL nop_out got %h exp %h", {out_valid, out_rd, out_rwe, out_load}, {1'b1, 5'd0, 1'b0, 1'b0}); else pass_cnt++;
    step();
    in_valid = 0;
    #3 reset = 1;
    #1;
    tot_cnt++; if ({out_valid, in_ready, out_rwe, out_wdata} !== '0) $display("FAIL async_reset got %h exp 0", {out_valid, in_ready, out_rwe, out_wdata}); else pass_cnt++;
    step();
    reset = 0;
    step();
    tot_cnt++; if ({out_valid, in_ready} !== 2'b01) $display("FAIL post_reset got %b exp 01", {out_valid, in_ready}); else pass_cnt++;
    q.delete();
  endtask

  task automatic test_random();
    logic [5:0] a;
    logic w, tk, acc, drn;
    logic [31:0] wd, da, tg;
    mb_t mb, hd;
    for (int n = 0; n < 600; n++) begin
      in_valid = $urandom_range(0, 9) < 7;
      flush = $urandom_range(0, 19) == 0;
      out_ready = $urandom_range(0, 9) < 6;
      itype = 2'($urandom_range(0, 3));
      sub_op = 3'($urandom_range(0, 7));
      op = 6'($urandom);
      pc = $urandom; imm = $urandom; rv2 = $urandom;
      rvout = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 1)) : $urandom;
      rd = 5'($urandom);
      is_nop = $urandom_range(0, 9) == 0;
      is_load = $urandom_range(0, 3) == 0;
      is_store = $urandom_range(0, 3) == 0;
      #1;
      dec(a, w, wd, da, tk, tg);
      tot_cnt++; if (in_ready !== (q.size() < 2)) $display("FAIL rnd_in_ready n=%0d got %h exp %h", n, in_ready, q.size() < 2); else pass_cnt++;
      tot_cnt++; if (out_valid !== (q.size() > 0)) $display("FAIL rnd_out_valid n=%0d got %h exp %h", n, out_valid, q.size() > 0); else pass_cnt++;
      tot_cnt++; if (redir_valid !== (tk && q.size() < 2 && !flush)) $display("FAIL rnd_redir n=%0d got %h exp %h", n, redir_valid, tk && q.size() < 2 && !flush); else pass_cnt++;
      tot_cnt++; if ({alu_op, fwd_rwe, fwd_rd, fwd_wdata} !== {a, w && rd != 0, rd, wd}) $display("FAIL rnd_decode n=%0d got %h exp %h", n, {alu_op, fwd_rwe, fwd_rd, fwd_wdata}, {a, w && rd != 0, rd, wd}); else pass_cnt++;
      if (tk) begin
        tot_cnt++; if (redir_pc !== tg) $display("FAIL rnd_redir_pc n=%0d got %h exp %h", n, redir_pc, tg); else pass_cnt++;
      end
      if (q.size() > 0) begin
        hd = q[0];
        tot_cnt++; if ({out_sub_op, out_daddr, out_wdata, out_rd, out_rv2, out_rwe, out_load, out_store} !== hd) $display("FAIL rnd_head n=%0d got %h exp %h", n, {out_sub_op, out_daddr, out_wdata, out_rd, out_rv2, out_rwe, out_load, out_store}, hd); else pass_cnt++;
      end else begin
        tot_cnt++; if ({out_rwe, out_load, out_store} !== 3'b0) $display("FAIL rnd_idle_flags n=%0d got %b exp 000", n, {out_rwe, out_load, out_store}); else pass_cnt++;
      end
      mb = '{s: sub_op, da: da, wd: wd, rd: is_nop ? 5'd0 : rd, rv2: rv2, w: w, ld: is_load && !is_nop, st: is_store && !is_nop};
      acc = in_valid && q.size() < 2 && !flush;
      drn = q.size() > 0 && out_ready;
      if (flush) q.delete();
      else begin
        if (drn) void'(q.pop_front());
        if (acc) q.push_back(mb);
      end
      step();
    end
    in_valid = 0; flush = 0;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_branch();
    test_jump();
    test_skid();
    test_flush();
    test_nop_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule

// File: doc/ex_mem_pipe.md
EX_MEM_PIPE -- requirements
Module: ex_mem_pipe

Interface
REQ-001 Parameter XLEN, default 32, datapath/PC width (>=32).
REQ-002 Parameter RW, default 5, register-index width.
REQ-003 Parameter SKID, default 1; 1 = 2-entry skid buffer, 0 = single entry, in_ready combinational.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-006 in_valid/in_ready  in/out  1/1  EX-side handshake; beat transfers when both high at a rising edge.
REQ-007 pc, imm, rvout, rv2  in  XLEN each  EX PC, immediate, ALU result, rs2 value.
REQ-008 op  in  6; itype  in  2; sub_op  in  3; rd  in  RW; is_load, is_store, is_nop  in  1.
REQ-009 flush  in  1  discard all held and incoming beats this cycle.
REQ-010 alu_op  out  6  combinational ALU control for the EX beat.
REQ-011 redir_valid/redir_pc  out  1/XLEN  combinational taken-branch/jump redirect.
REQ-012 fwd_rwe/fwd_rd/fwd_wdata  out  1/RW/XLEN  combinational EX write info for forwarding.
REQ-013 out_valid/out_ready  out/in  1/1  MEM-side handshake.
REQ-014 out_sub_op 3, out_daddr XLEN, out_wdata XLEN, out_rd RW, out_rv2 XLEN, out_rwe 1, out_load 1, out_store 1  out  head-entry fields.

Function
REQ-015 EX decode (only when in_valid && !is_nop; else alu_op=0, rwe=0, redir_valid=0): itype 00 -> alu_op=op, wdata=rvout, rwe=1; 01 -> alu_op=6'b001000, daddr=rvout, rwe=0.
REQ-016 itype 10: sub_op 000/001 alu_op=6'b111000, taken if rvout==0 / !=0; 100/101 alu_op=6'b101010, taken if rvout[0] / !rvout[0]; 110/111 alu_op=6'b101011, same tests; others not taken; taken -> redir_pc=pc+imm.
REQ-017 itype 11, rwe=1: 100 JALR alu_op=6'b001000, wdata=pc+4, redir_pc={rvout[XLEN-1:1],0}; 101 JAL wdata=pc+4, redir_pc=pc+imm; 010 AUIPC wdata=pc+imm; 110 LUI wdata=imm; other sub_op wdata=0.
REQ-018 All arithmetic modulo 2^XLEN, wrap without flag.
REQ-019 redir_valid asserted only when beat is accepted (in_valid && in_ready) and flush low.
REQ-020 fwd_* = decoded rwe/rd/wdata of current EX beat, fwd_rwe forced 0 if not in_valid or is_nop or rd==0.
REQ-021 Stored beat = decoded fields; is_nop beat stored with rd=0, rwe=0, load=0, store=0.
REQ-022 SKID=1: in_ready = !skid_valid (registered); accepted beat goes to head if head empty or head drains same cycle, else to skid; skid moves to head when head drains.
REQ-023 SKID=0: in_ready = !out_valid || out_ready; one register stage.
REQ-024 Head drains when out_valid && out_ready; order strictly FIFO; latency in->out 1 cycle when empty.
REQ-025 Full (head and skid valid, out_ready low): in_ready=0, contents held unchanged.
REQ-026 Simultaneous accept and drain with skid empty: new beat replaces head, throughput 1/cycle.
REQ-027 flush high: head and skid valid cleared at edge, incoming beat dropped; flush overrides accept and drain.
REQ-028 out_* reflect head fields only; out_valid=0 means out_rwe, out_load, out_store forced 0.

Reset
REQ-029 reset high: out_valid=0, skid_valid=0, all out_* = 0, in_ready=0; in_ready=1 first cycle after deassertion.
REQ-030 Reset mid-transfer: held beats lost, no partial beat emitted, redir_valid=0 while reset high.

Verification
REQ-031 ALU beat op=6'b100000, rvout=0x1234, rd=7, out_ready=1 -> next cycle out_valid=1, out_wdata=0x1234, out_rd=7, out_rwe=1; fwd_rwe=1 same cycle.
REQ-032 BEQ pc=0x100, imm=0x20, rvout=0 -> redir_valid=1, redir_pc=0x120, alu_op=6'b111000; rvout=1 -> redir_valid=0.
REQ-033 JALR rvout=0x203, pc=0x40 -> redir_pc=0x202, wdata=0x44; JAL pc=0xFFFFFFFC, imm=8 -> redir_pc=0x4 (wrap).
REQ-034 SKID=1, out_ready=0, push A,B -> in_ready=0 after B; out_ready=1 -> A then B on consecutive cycles, in_ready returns 1.
REQ-035 Full buffer plus flush with in_valid=1 -> next cycle out_valid=0, beat dropped, redir_valid=0.
REQ-036 is_nop beat rd=9 -> out_rd=0, out_rwe=0; reset pulse mid-stream -> out_valid=0 immediately, asynchronously.
